id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-low. The clock port is clk and the reset port is resetn.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous active-low reset.
REQ-004 id_valid  input  1  decode slot holds a real instruction.
REQ-005 id_pc  input  32  PC of decode instruction.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-007 id_rs1_used, id_rs2_used  input  1 each  instruction actually reads rs1/rs2.
REQ-008 id_imm  input  32  sign-extended immediate.
REQ-009 id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_jump  input  1 each  decoded controls.
REQ-010 id_alu_op  input  4; id_result_src  input  2  decoded controls.
REQ-011 rd1, rd2  input  32 each  register-file read data, stable before the rising edge (file updates them on falling edge).
REQ-012 flush_e  input  1  taken branch/jump resolved in EX; squash decode slot.
REQ-013 hold_e  input  1  downstream busy; freeze ID/EX contents.
REQ-014 ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_rd1, ex_rd2, all ex_<ctrl>  output  same widths as id_ counterparts  registered ID/EX contents.
REQ-015 stall_f, stall_d  output  1 each  freeze fetch PC and IF/ID register (combinational).
REQ-016 bubble_count, flush_count  output  16 each  saturating event counters.

Function
REQ-017 Load-use hazard lu = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)); combinational.
REQ-018 stall_f = stall_d = (lu & ~flush_e) | hold_e.
REQ-019 Per-edge priority, highest first: reset, flush_e, hold_e, lu, normal capture.
REQ-020 Flush: ex_valid <= 0, all ex_ control outputs <= 0; data fields unchanged.
REQ-021 Hold (no flush): every ex_ register keeps its value.
REQ-022 Load-use bubble (no flush, no hold): ex_valid <= 0, ex_ controls <= 0; decode instruction reissued next cycle by stall.
REQ-023 Normal capture: every ex_ output <= corresponding id_ input / rd1 / rd2; ex_valid <= id_valid.
REQ-024 When id_valid=0 at capture, ex_ controls are forced to 0 regardless of id_ control inputs.
REQ-025 Invariant: ex_valid=0 implies ex_reg_write=ex_mem_read=ex_mem_write=ex_branch=ex_jump=0.
REQ-026 Register x0: ex_rd=0 never raises lu; ex_reg_write passes through unchanged (x0 writes are ignored downstream).
REQ-027 Latency: one cycle ID->EX; a load-use costs exactly one bubble.
REQ-028 bubble_count +1 on each edge taking REQ-022; flush_count +1 on each edge taking REQ-020; both saturate at 0xFFFF, never wrap.
REQ-029 No counter increments on an edge where hold_e wins.

Reset
REQ-030 On a rising edge with resetn=0: all ex_ outputs <= 0 (incl. ex_valid, ex_pc, data), both counters <= 0.
REQ-031 During reset stall_f/stall_d follow REQ-018 using the reset-forced ex_ values (so lu=0).
REQ-032 Reset asserted mid-stall or mid-hold overrides both in the same edge; first post-reset edge performs normal capture.

Verification
REQ-033 Capture: id_valid=1, id_pc=0x100, rd1=0x11, rd2=0x22, id_rd=5, id_reg_write=1 -> next edge ex_pc=0x100, ex_rd1=0x11, ex_rd2=0x22, ex_rd=5, ex_valid=1.
REQ-034 Load-use: EX holds lw x5 (mem_read=1, rd=5), ID add x6,x5,x1 (rs1_used=1) -> stall_f=stall_d=1 one cycle, ex_valid=0 next edge, bubble_count=1, add captured the following edge.
REQ-035 False hazard: EX lw x0 or ID rs2=5 with rs2_used=0 -> stall_d=0, no bubble.
REQ-036 Flush vs lu/hold: flush_e=1 with lu=1 and hold_e=1 -> ex_valid=0, flush_count=1, bubble_count unchanged, stall_d=1 (hold).
REQ-037 Hold 3 cycles: ex_ contents constant, counters constant; release -> capture resumes.
REQ-038 Saturation and reset: force 0x10000 bubbles -> bubble_count=0xFFFF; resetn=0 one edge -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold
// handling and saturating bubble/flush event counters.
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  // decode slot
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [31:0]       id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [3:0]        id_alu_op,
  input  logic [1:0]        id_result_src,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  // pipeline control
  input  logic              flush_e,
  input  logic              hold_e,
  // execute slot
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_rd1,
  output logic [31:0]       ex_rd2,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [3:0]        ex_alu_op,
  output logic [1:0]        ex_result_src,
  // front-end stalls (combinational)
  output logic              stall_f,
  output logic              stall_d,
  // event counters
  output logic [CNT_W-1:0]  bubble_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned RES_SRC_W = 2;

  // Control bundle: cleared on flush/bubble/invalid capture.
  typedef struct packed {
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 alu_src;
    logic                 branch;
    logic                 jump;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [RES_SRC_W-1:0] result_src;
  } ctrl_t;

  // Data bundle: only ever loaded by a normal capture.
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
  } data_t;

  // Action taken on the next edge, in priority order below reset.
  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_FLUSH   = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_BUBBLE  = 2'd3
  } act_e;

  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  data_t            data_q, data_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  ctrl_t id_ctrl;
  data_t id_data;
  logic  lu;
  act_e  act;

  // Pack decode-slot inputs into bundles.
  always_comb begin
    id_ctrl            = '0;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.branch     = id_branch;
    id_ctrl.jump       = id_jump;
    id_ctrl.alu_op     = id_alu_op;
    id_ctrl.result_src = id_result_src;
    id_data            = '0;
    id_data.pc         = id_pc;
    id_data.rs1        = id_rs1;
    id_data.rs2        = id_rs2;
    id_data.rd         = id_rd;
    id_data.imm        = id_imm;
    id_data.rd1        = rd1;
    id_data.rd2        = rd2;
  end

  // Load-use hazard: EX load writes a register the decode instruction reads (x0 excluded).
  always_comb begin
    lu = id_valid & valid_q & ctrl_q.mem_read & (data_q.rd != '0) &
         ((id_rs1_used & (id_rs1 == data_q.rd)) |
          (id_rs2_used & (id_rs2 == data_q.rd)));
  end

  assign stall_f = (lu & ~flush_e) | hold_e;
  assign stall_d = (lu & ~flush_e) | hold_e;

  // Select the edge action: flush beats hold beats load-use bubble.
  always_comb begin
    act = ACT_CAPTURE;
    if (flush_e) begin
      act = ACT_FLUSH;
    end else if (hold_e) begin
      act = ACT_HOLD;
    end else if (lu) begin
      act = ACT_BUBBLE;
    end
  end

  // Next-state for the pipeline register and counters.
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    case (act)
      ACT_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (flush_q != {CNT_W{1'b1}}) begin
          flush_d = flush_q + CNT_W'(1);
        end
      end
      ACT_HOLD: begin
        valid_d = valid_q;
      end
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (bubble_q != {CNT_W{1'b1}}) begin
          bubble_d = bubble_q + CNT_W'(1);
        end
      end
      ACT_CAPTURE: begin
        valid_d = id_valid;
        ctrl_d  = id_valid ? id_ctrl : '0;
        data_d  = id_data;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      data_q   <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = data_q.pc;
  assign ex_rs1        = data_q.rs1;
  assign ex_rs2        = data_q.rs2;
  assign ex_rd         = data_q.rd;
  assign ex_imm        = data_q.imm;
  assign ex_rd1        = data_q.rd1;
  assign ex_rd2        = data_q.rd2;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_result_src = ctrl_q.result_src;
  assign bubble_count  = bubble_q;
  assign flush_count   = flush_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences for
// hold, full-field capture, counter saturation and reset.
module tb_id_ex_stage;

  logic        clk;
  logic        resetn;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic [31:0] id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch, id_jump;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_result_src;
  logic [31:0] rd1, rd2;
  logic        flush_e, hold_e;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_result_src;
  logic        stall_f, stall_d;
  logic [15:0] bubble_count, flush_count;

  // narrow-counter instance, same inputs, used to reach saturation quickly
  logic        s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_imm, s_ex_rd1, s_ex_rd2;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic        s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_alu_src, s_ex_branch, s_ex_jump;
  logic [3:0]  s_ex_alu_op;
  logic [1:0]  s_ex_result_src;
  logic        s_stall_f, s_stall_d;
  logic [3:0]  s_bubble_count, s_flush_count;

  int n_cmp;
  int n_fail;

  id_ex_stage dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_result_src(id_result_src), .rd1(rd1), .rd2(rd2),
    .flush_e(flush_e), .hold_e(hold_e),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_op(ex_alu_op), .ex_result_src(ex_result_src),
    .stall_f(stall_f), .stall_d(stall_d),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  id_ex_stage #(.CNT_W(4)) u_small (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_result_src(id_result_src), .rd1(rd1), .rd2(rd2),
    .flush_e(flush_e), .hold_e(hold_e),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
    .ex_imm(s_ex_imm), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
    .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write),
    .ex_alu_src(s_ex_alu_src), .ex_branch(s_ex_branch), .ex_jump(s_ex_jump),
    .ex_alu_op(s_ex_alu_op), .ex_result_src(s_ex_result_src),
    .stall_f(s_stall_f), .stall_d(s_stall_d),
    .bubble_count(s_bubble_count), .flush_count(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, fl, hd, v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        mr, rw;
    logic [31:0] r1, r2;
    logic        x_st, x_v;
    logic [31:0] x_pc;
    logic [4:0]  x_rd;
    logic        x_rw, x_mr;
    logic [31:0] x_r1;
    logic [15:0] x_bub, x_fl;
  } vec_t;

  function automatic vec_t mk(
      input int unsigned rst_n, fl, hd, v, pc, rs1, u1, rs2, u2, rd, mr, rw, r1, r2,
      input int unsigned x_st, x_v, x_pc, x_rd, x_rw, x_mr, x_r1, x_bub, x_fl);
    vec_t t;
    t.rst_n = 1'(rst_n); t.fl = 1'(fl); t.hd = 1'(hd); t.v = 1'(v);
    t.pc = 32'(pc); t.rs1 = 5'(rs1); t.u1 = 1'(u1); t.rs2 = 5'(rs2); t.u2 = 1'(u2);
    t.rd = 5'(rd); t.mr = 1'(mr); t.rw = 1'(rw); t.r1 = 32'(r1); t.r2 = 32'(r2);
    t.x_st = 1'(x_st); t.x_v = 1'(x_v); t.x_pc = 32'(x_pc); t.x_rd = 5'(x_rd);
    t.x_rw = 1'(x_rw); t.x_mr = 1'(x_mr); t.x_r1 = 32'(x_r1);
    t.x_bub = 16'(x_bub); t.x_fl = 16'(x_fl);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_imm = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_alu_src = 1'b0; id_branch = 1'b0; id_jump = 1'b0;
    id_alu_op = '0; id_result_src = '0; rd1 = '0; rd2 = '0;
    flush_e = 1'b0; hold_e = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'h0);
    chk({tag, "_pc"}, ex_pc, 32'h0);
    chk({tag, "_rs1"}, 32'(ex_rs1), 32'h0);
    chk({tag, "_rs2"}, 32'(ex_rs2), 32'h0);
    chk({tag, "_rd"}, 32'(ex_rd), 32'h0);
    chk({tag, "_imm"}, ex_imm, 32'h0);
    chk({tag, "_rd1"}, ex_rd1, 32'h0);
    chk({tag, "_rd2"}, ex_rd2, 32'h0);
    chk({tag, "_ctrl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                             ex_branch, ex_jump, ex_alu_op, ex_result_src}), 32'h0);
    chk({tag, "_bub"}, 32'(bubble_count), 32'h0);
    chk({tag, "_fl"}, 32'(flush_count), 32'h0);
    chk({tag, "_sbub"}, 32'(s_bubble_count), 32'h0);
    chk({tag, "_sfl"}, 32'(s_flush_count), 32'h0);
    chk({tag, "_stall"}, 32'({stall_f, stall_d}), 32'h0);
  endtask

  vec_t tbl[17];

  initial begin
    n_cmp = 0;
    n_fail = 0;
    clear_inputs();
    resetn = 1'b0;

    //          rst fl hd v  pc      rs1 u1 rs2 u2 rd mr rw r1      r2     | st v  pc     rd rw mr r1     bub fl
    tbl[0]  = mk(0, 0, 0, 1, 'h50,   5,  1, 0,  0, 5, 1, 1, 'h99,   'h98,    0, 0, 0,     0, 0, 0, 0,     0,  0);
    tbl[1]  = mk(1, 0, 0, 1, 'h100,  1,  1, 2,  1, 5, 0, 1, 'h11,   'h22,    0, 1, 'h100, 5, 1, 0, 'h11,  0,  0);
    tbl[2]  = mk(1, 0, 0, 1, 'h104,  2,  1, 0,  0, 5, 1, 1, 'h33,   0,       0, 1, 'h104, 5, 1, 1, 'h33,  0,  0);
    tbl[3]  = mk(1, 0, 0, 1, 'h108,  5,  1, 1,  1, 6, 0, 1, 'h44,   'h55,    1, 0, 'h104, 5, 0, 0, 'h33,  1,  0);
    tbl[4]  = mk(1, 0, 0, 1, 'h108,  5,  1, 1,  1, 6, 0, 1, 'h44,   'h55,    0, 1, 'h108, 6, 1, 0, 'h44,  1,  0);
    tbl[5]  = mk(1, 0, 0, 1, 'h10C,  6,  1, 0,  0, 0, 1, 1, 'h66,   0,       0, 1, 'h10C, 0, 1, 1, 'h66,  1,  0);
    tbl[6]  = mk(1, 0, 0, 1, 'h110,  0,  1, 0,  1, 7, 1, 1, 'h77,   0,       0, 1, 'h110, 7, 1, 1, 'h77,  1,  0);
    tbl[7]  = mk(1, 0, 0, 1, 'h114,  3,  1, 7,  0, 8, 0, 1, 'h88,   0,       0, 1, 'h114, 8, 1, 0, 'h88,  1,  0);
    tbl[8]  = mk(1, 0, 0, 1, 'h118,  1,  1, 0,  0, 9, 1, 1, 'h90,   0,       0, 1, 'h118, 9, 1, 1, 'h90,  1,  0);
    tbl[9]  = mk(1, 1, 1, 1, 'h11C,  1,  0, 9,  1, 10,0, 1, 'hA0,   0,       1, 0, 'h118, 9, 0, 0, 'h90,  1,  1);
    tbl[10] = mk(1, 1, 0, 1, 'h120,  0,  0, 0,  0, 11,0, 1, 'hB0,   0,       0, 0, 'h118, 9, 0, 0, 'h90,  1,  2);
    tbl[11] = mk(1, 0, 0, 0, 'h124,  0,  0, 0,  0, 12,1, 1, 'hC0,   0,       0, 0, 'h124, 12,0, 0, 'hC0,  1,  2);
    tbl[12] = mk(1, 0, 0, 1, 'h128,  0,  0, 0,  0, 13,1, 1, 'hD0,   0,       0, 1, 'h128, 13,1, 1, 'hD0,  1,  2);
    tbl[13] = mk(1, 1, 0, 1, 'h12C,  13, 1, 0,  0, 14,0, 1, 'hE0,   0,       0, 0, 'h128, 13,0, 0, 'hD0,  1,  3);
    tbl[14] = mk(1, 0, 0, 1, 'h130,  0,  0, 0,  0, 13,1, 1, 'hF0,   0,       0, 1, 'h130, 13,1, 1, 'hF0,  1,  3);
    tbl[15] = mk(0, 0, 0, 1, 'h134,  13, 1, 0,  0, 15,0, 1, 'h1234, 0,       1, 0, 0,     0, 0, 0, 0,     0,  0);
    tbl[16] = mk(1, 0, 0, 1, 'h134,  13, 1, 0,  0, 15,0, 1, 'h1234, 0,       0, 1, 'h134, 15,1, 0, 'h1234,0,  0);

    tick();
    tick();

    // table: stall checked before the edge, registered state after it
    for (int i = 0; i < 17; i++) begin
      resetn = tbl[i].rst_n; flush_e = tbl[i].fl; hold_e = tbl[i].hd;
      id_valid = tbl[i].v; id_pc = tbl[i].pc; id_imm = tbl[i].pc ^ 32'h0F0F_0000;
      id_rs1 = tbl[i].rs1; id_rs1_used = tbl[i].u1;
      id_rs2 = tbl[i].rs2; id_rs2_used = tbl[i].u2; id_rd = tbl[i].rd;
      id_mem_read = tbl[i].mr; id_reg_write = tbl[i].rw;
      rd1 = tbl[i].r1; rd2 = tbl[i].r2;
      #1;
      chk($sformatf("v%0d_stall_f", i), 32'(stall_f), 32'(tbl[i].x_st));
      chk($sformatf("v%0d_stall_d", i), 32'(stall_d), 32'(tbl[i].x_st));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(tbl[i].x_v));
      chk($sformatf("v%0d_pc", i), ex_pc, tbl[i].x_pc);
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(tbl[i].x_rd));
      chk($sformatf("v%0d_regwr", i), 32'(ex_reg_write), 32'(tbl[i].x_rw));
      chk($sformatf("v%0d_memrd", i), 32'(ex_mem_read), 32'(tbl[i].x_mr));
      chk($sformatf("v%0d_rd1", i), ex_rd1, tbl[i].x_r1);
      chk($sformatf("v%0d_bub", i), 32'(bubble_count), 32'(tbl[i].x_bub));
      chk($sformatf("v%0d_fl", i), 32'(flush_count), 32'(tbl[i].x_fl));
    end

    // full-field capture
    clear_inputs();
    id_valid = 1'b1; id_pc = 32'hDEAD_BEEF; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd9;
    id_imm = 32'hFFFF_FFF0; rd1 = 32'hCAFE_0001; rd2 = 32'hCAFE_0002;
    id_reg_write = 1'b1; id_mem_write = 1'b1; id_alu_src = 1'b1; id_branch = 1'b1;
    id_alu_op = 4'hA; id_result_src = 2'b10;
    tick();
    chk("full_valid", 32'(ex_valid), 32'h1);
    chk("full_pc", ex_pc, 32'hDEAD_BEEF);
    chk("full_rs1", 32'(ex_rs1), 32'd3);
    chk("full_rs2", 32'(ex_rs2), 32'd4);
    chk("full_imm", ex_imm, 32'hFFFF_FFF0);
    chk("full_rd2", ex_rd2, 32'hCAFE_0002);
    chk("full_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                          ex_branch, ex_jump, ex_alu_op, ex_result_src}), 32'b1_0_1_1_1_0_1010_10);

    // invalid decode slot with every control asserted still yields zero controls
    id_valid = 1'b0; id_mem_read = 1'b1; id_jump = 1'b1; id_alu_op = 4'hF; id_result_src = 2'b11;
    tick();
    chk("inv_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                         ex_branch, ex_jump, ex_alu_op, ex_result_src}), 32'h0);
    chk("inv_valid", 32'(ex_valid), 32'h0);

    // hold 3 cycles over a load with a dependent decode instruction
    clear_inputs();
    id_valid = 1'b1; id_pc = 32'h200; id_rd = 5'd4; id_mem_read = 1'b1; id_reg_write = 1'b1;
    rd1 = 32'h200;
    tick();
    chk("ld_memrd", 32'(ex_mem_read), 32'h1);
    hold_e = 1'b1;
    id_pc = 32'h204; id_rs1 = 5'd4; id_rs1_used = 1'b1; id_rd = 5'd6; id_mem_read = 1'b0;
    rd1 = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_stall", k), 32'({stall_f, stall_d}), 32'h3);
      tick();
      chk($sformatf("hold%0d_pc", k), ex_pc, 32'h200);
      chk($sformatf("hold%0d_valid", k), 32'(ex_valid), 32'h1);
      chk($sformatf("hold%0d_memrd", k), 32'(ex_mem_read), 32'h1);
      chk($sformatf("hold%0d_rd1", k), ex_rd1, 32'h200);
      chk($sformatf("hold%0d_cnt", k), {bubble_count, flush_count}, 32'h0000_0000);
    end
    hold_e = 1'b0;
    #1;
    chk("rel_stall", 32'(stall_d), 32'h1);
    tick();
    chk("rel_bub_valid", 32'(ex_valid), 32'h0);
    chk("rel_bub_cnt", 32'(bubble_count), 32'h1);
    chk("rel_nostall", 32'(stall_d), 32'h0);
    tick();
    chk("rel_cap_pc", ex_pc, 32'h204);
    chk("rel_cap_valid", 32'(ex_valid), 32'h1);
    chk("rel_cap_bub", 32'(bubble_count), 32'h1);

    // saturation on the narrow counter instance
    clear_inputs();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    flush_e = 1'b1;
    repeat (20) tick();
    chk("sat_sfl", 32'(s_flush_count), 32'hF);
    chk("sat_fl", 32'(flush_count), 32'd20);
    chk("sat_sbub0", 32'(s_bubble_count), 32'h0);
    flush_e = 1'b0;
    id_valid = 1'b1; id_pc = 32'h300; id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rd = 5'd5;
    id_mem_read = 1'b1; id_reg_write = 1'b1;
    repeat (34) tick();
    chk("sat_sbub", 32'(s_bubble_count), 32'hF);
    chk("sat_bub", 32'(bubble_count), 32'd17);
    chk("sat_sfl_keep", 32'(s_flush_count), 32'hF);

    // single reset edge clears everything in both instances
    resetn = 1'b0;
    id_imm = 32'h1234_5678; rd1 = 32'h1; rd2 = 32'h2;
    tick();
    chk_all_zero("rst");
    resetn = 1'b1;
    tick();
    chk("post_rst_pc", ex_pc, 32'h300);
    chk("post_rst_valid", 32'(ex_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
